// File: rtl/assoc_metadata.sv
// assoc_metadata: N-way set-associative tag/valid/dirty store with tree PLRU and a flush-all sweep.
// Optional hit/miss counters are enabled by defining ASSOC_METADATA_PERF_CNT_EN.
module assoc_metadata #(
   parameter int NUM_SETS       = 16,
   parameter int SET_SIZE       = 4,
   parameter int NUM_WAYS       = 4,
   parameter int TAG_SIZE       = 28,
   parameter int READ_ONLY      = 0,
   parameter int PERF_CNT_WIDTH = 32,
   localparam int WAY_BITS      = $clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SET_SIZE-1:0] set,
   input  logic [TAG_SIZE-1:0] tag,
   input  logic                lookup,
   input  logic                clear_selected_valid_bit,
   input  logic                finish_new_line_install,
   input  logic                set_selected_dirty_bit,
   input  logic                clear_selected_dirty_bit,
   input  logic                invalidate_all_req,
   output logic                valid_block_match,
   output logic [WAY_BITS-1:0] hit_way,
   output logic [WAY_BITS-1:0] victim_way,
   output logic [TAG_SIZE-1:0] victim_tag,
   output logic                victim_valid_dirty,
   output logic                invalidate_busy
`ifdef ASSOC_METADATA_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] hit_count,
   output logic [PERF_CNT_WIDTH-1:0] miss_count
`endif
);
   typedef enum logic {IDLE, SWEEP} state_t;
   state_t              state_q;
   logic [SET_SIZE-1:0] cnt_q;
   logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
   logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
   logic [NUM_WAYS-1:0] match, valid_set, dirty_set, valid_set_d, dirty_set_d;
   logic [NUM_WAYS-2:0] plru_set, plru_set_d;
   logic [WAY_BITS-1:0] plru_way, inv_way, touch_way;
   logic                busy, hit, install, touch;
   int                  node, tnode;
   assign busy            = state_q == SWEEP;
   assign invalidate_busy = busy;
   assign valid_set       = valid_q[set];
   assign dirty_set       = dirty_q[set];
   assign plru_set        = plru_q[set];
   always_comb begin
      match   = '0;
      hit_way = '0;
      inv_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         match[w] = valid_set[w] && tag_q[set][w] == tag;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way = WAY_BITS'(w);
         if (!valid_set[w]) inv_way = WAY_BITS'(w);
      end
      hit = !busy && |match;
      hit_way = hit ? hit_way : '0;
      node = 0;
      plru_way = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         plru_way[WAY_BITS-1-l] = plru_set[node];
         node = 2 * node + 1 + int'(plru_set[node]);
      end
   end
   assign valid_block_match  = hit;
   assign victim_way         = &valid_set ? plru_way : inv_way;
   assign victim_tag         = tag_q[set][victim_way];
   assign victim_valid_dirty = READ_ONLY == 0 && valid_set[victim_way] && dirty_set[victim_way];
   assign install            = !busy && !clear_selected_valid_bit && finish_new_line_install;
   assign touch              = install || (lookup && hit);
   assign touch_way          = install ? victim_way : hit_way;
   // Only the highest-priority requested op takes effect; the rest are dropped.
   always_comb begin
      valid_set_d = valid_set;
      dirty_set_d = dirty_set;
      if (clear_selected_valid_bit) begin
         if (hit) valid_set_d[hit_way] = 1'b0;
      end else if (install) begin
         valid_set_d[victim_way] = 1'b1;
         dirty_set_d[victim_way] = 1'b0;
      end else if (clear_selected_dirty_bit) begin
         if (hit) dirty_set_d[hit_way] = 1'b0;
      end else if (set_selected_dirty_bit && hit) begin
         dirty_set_d[hit_way] = 1'b1;
      end
      dirty_set_d = READ_ONLY != 0 ? '0 : dirty_set_d;
      plru_set_d = plru_set;
      tnode = 0;
      for (int l = 0; l < WAY_BITS; l++) begin
         if (touch) plru_set_d[tnode] = ~touch_way[WAY_BITS-1-l];
         tnode = 2 * tnode + 1 + int'(touch_way[WAY_BITS-1-l]);
      end
   end
   always_ff @(posedge clk)
      if (install) tag_q[set][victim_way] <= tag;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else if (busy) begin
         valid_q[cnt_q] <= '0;
         dirty_q[cnt_q] <= '0;
         plru_q[cnt_q]  <= '0;
         cnt_q          <= cnt_q + 1'b1;
         if (cnt_q == SET_SIZE'(NUM_SETS - 1)) state_q <= IDLE;
      end else begin
         valid_q[set] <= valid_set_d;
         dirty_q[set] <= dirty_set_d;
         plru_q[set]  <= plru_set_d;
         if (invalidate_all_req) state_q <= SWEEP;
      end
`ifdef ASSOC_METADATA_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (!busy && lookup) begin
         if (hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (!hit && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_assoc_metadata.sv
// tb_assoc_metadata: directed checks of lookup, install, PLRU, dirty priority and the flush sweep.
module tb_assoc_metadata;
   logic        clk = 1'b0;
   logic        reset, lookup, clr_v, inst, set_d, clr_d, inv;
   logic [3:0]  set;
   logic [27:0] tag;
   logic        vbm, vvd, busy;
   logic [1:0]  hit_way, victim_way;
   logic [27:0] victim_tag;
   int          checks = 0, errors = 0, n;
   logic [27:0] ta [4] = '{28'h000000A, 28'h000000B, 28'h000000C, 28'h000000D};
   logic [27:0] tb [5] = '{28'h1234567, 28'h89ABCDE, 28'h0F0F0F0, 28'hA5A5A5A, 28'h0FEDCBA};
`ifdef ASSOC_METADATA_PERF_CNT_EN
   logic [31:0] hit_count, miss_count;
`endif
   always #5 clk = ~clk;
   assoc_metadata #(.NUM_SETS(16), .SET_SIZE(4), .NUM_WAYS(4), .TAG_SIZE(28)) dut (
      .clk(clk), .reset(reset), .set(set), .tag(tag), .lookup(lookup),
      .clear_selected_valid_bit(clr_v), .finish_new_line_install(inst),
      .set_selected_dirty_bit(set_d), .clear_selected_dirty_bit(clr_d),
      .invalidate_all_req(inv), .valid_block_match(vbm), .hit_way(hit_way),
      .victim_way(victim_way), .victim_tag(victim_tag),
      .victim_valid_dirty(vvd), .invalidate_busy(busy)
`ifdef ASSOC_METADATA_PERF_CNT_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask
   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1; {clr_v, inst, set_d, clr_d, inv} = '0;
      set = 4'd3; tag = 28'h5; lookup = 1'b1;
      step; step; #1;
      chk("rst_vbm", 32'(vbm), 0);
      chk("rst_hit_way", 32'(hit_way), 0);
      chk("rst_victim", 32'(victim_way), 0);
      chk("rst_vvd", 32'(vvd), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0; lookup = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tag = ta[i]; inst = 1'b1; #1;
         chk("install_victim", 32'(victim_way), 32'(i));
         step;
      end
      inst = 1'b0;
      tag = ta[0]; lookup = 1'b1; #1;
      chk("hitA_vbm", 32'(vbm), 1);
      chk("hitA_way", 32'(hit_way), 0);
      step; lookup = 1'b0; #1;
      chk("after_A_victim", 32'(victim_way), 2);
      chk("after_A_vtag", 32'(victim_tag), 32'(ta[2]));
      tag = ta[1]; #1;
      chk("hitB_way", 32'(hit_way), 1);
      set = 4'd1;
      for (int i = 0; i < 4; i++) begin
         tag = tb[i]; inst = 1'b1; step;
      end
      inst = 1'b0; #1;
      chk("set1_full_victim", 32'(victim_way), 0);
      for (int i = 0; i < 4; i++) begin
         tag = tb[i]; lookup = 1'b1; step;
      end
      lookup = 1'b0; #1;
      chk("touch0123_victim", 32'(victim_way), 0);
      tag = tb[0]; lookup = 1'b1; step; lookup = 1'b0; #1;
      chk("touch0_victim", 32'(victim_way), 2);
      tag = tb[2]; set_d = 1'b1; step; set_d = 1'b0; #1;
      chk("dirty2_vvd", 32'(vvd), 1);
      chk("dirty2_vtag", 32'(victim_tag), 32'(tb[2]));
      tag = tb[0]; clr_v = 1'b1; set_d = 1'b1; step; clr_v = 1'b0; set_d = 1'b0; #1;
      chk("clrv_vbm", 32'(vbm), 0);
      chk("clrv_victim", 32'(victim_way), 0);
      chk("clrv_vvd", 32'(vvd), 0);
      tag = tb[4]; inst = 1'b1; step; inst = 1'b0; #1;
      chk("reinst_vbm", 32'(vbm), 1);
      chk("reinst_hit_way", 32'(hit_way), 0);
      chk("reinst_victim", 32'(victim_way), 2);
      chk("reinst_vvd", 32'(vvd), 1);
      tag = tb[2]; clr_d = 1'b1; set_d = 1'b1; step; clr_d = 1'b0; set_d = 1'b0; #1;
      chk("clrd_wins_vvd", 32'(vvd), 0);
      tag = 28'hDEAD; clr_v = 1'b1; step; clr_v = 1'b0;
      tag = tb[4]; #1;
      chk("miss_clrv_noop", 32'(vbm), 1);
      set = 4'd3; tag = ta[0]; inv = 1'b1; step; inv = 1'b0; lookup = 1'b1; #1;
      chk("sweep_busy", 32'(busy), 1);
      chk("sweep_vbm", 32'(vbm), 0);
      n = 0;
      while (busy && n < 40) begin
         step; n++;
      end
      chk("sweep_len", 32'(n), 16);
      lookup = 1'b0;
      for (int s = 0; s < 16; s++) begin
         set = 4'(s); tag = ta[0]; #1;
         chk("post_sweep_vbm", 32'(vbm), 0);
         chk("post_sweep_victim", 32'(victim_way), 0);
      end
      set = 4'd1; tag = tb[1]; #1;
      chk("post_sweep_set1", 32'(vbm), 0);
      set = 4'd5; tag = ta[0]; inst = 1'b1; step; inst = 1'b0; #1;
      chk("set5_installed", 32'(vbm), 1);
      inv = 1'b1; step; inv = 1'b0;
      repeat (4) step;
      chk("mid_sweep_busy", 32'(busy), 1);
      reset = 1'b1; #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_set5_vbm", 32'(vbm), 0);
      reset = 1'b0; step; step;
      chk("after_reset_busy", 32'(busy), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
